// File: rtl/tone_sample_source_if.sv
// Stereo frame stream between the tone source and the I2S driver.
// First-word fall-through valid/ready handshake.
interface tone_sample_source_if;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/tone_sample_source.sv
// Phase-accumulator tone generator feeding a small FWFT frame FIFO.
// One sample per IDLE/COMPUTE/PUSH pass; frames are {s, s}.
module tone_sample_source #(
  parameter int PHASE_W    = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_i,
  input  logic [PHASE_W-1:0] tune_word_i,
  input  logic               tune_load_i,
  input  logic [1:0]         wave_sel_i,
  input  logic [2:0]         volume_i,
  tone_sample_source_if.master frm,
  output logic [LVL_W-1:0]   fifo_level_o,
  output logic               underrun_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL =
    LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_PUSH
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] tune_q, phase_q;
  logic [15:0]        raw_q, raw_d;
  logic [2:0]         vol_q;
  logic [31:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               underrun_q;

  logic        valid, push, pop;
  logic [15:0] p, tri_t, scaled;

  assign valid  = (level_q != '0);
  assign push   = (state_q == S_PUSH);
  assign pop    = valid & frm.frame_ready;
  assign scaled = 16'($signed(raw_q) >>> vol_q);

  assign frm.frame_data  = mem_q[rd_ptr_q];
  assign frm.frame_valid = valid;
  assign fifo_level_o    = level_q;
  assign underrun_o      = underrun_q;

  // Next-state logic for the sample sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (enable_i && (level_q < FULL))
          state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_PUSH;
      S_PUSH:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Raw waveform from the top 16 phase bits.
  always_comb begin
    p     = phase_q[PHASE_W-1 -: 16];
    tri_t = {p[14:0], 1'b0};
    raw_d = 16'h0000;
    unique case (wave_sel_i)
      2'd0: raw_d = p[15] ? 16'h8000 : 16'h7FFF;
      2'd1: raw_d = p ^ 16'h8000;
      2'd2: raw_d = p[15] ? (~tri_t ^ 16'h8000)
                          : (tri_t ^ 16'h8000);
      default: raw_d = 16'h0000;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  // Tuning word; phase advances once per pushed sample.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tune_q  <= '0;
      phase_q <= '0;
    end else begin
      if (tune_load_i) tune_q <= tune_word_i;
      if (push)        phase_q <= phase_q + tune_q;
    end

  // Capture raw sample and volume during COMPUTE.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      raw_q <= '0;
      vol_q <= '0;
    end else if (state_q == S_COMPUTE) begin
      raw_q <= raw_d;
      vol_q <= volume_i;
    end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {scaled, scaled};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end

  // Sticky underrun; a new request beats the clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      underrun_q <= 1'b0;
    else if (enable_i && frm.frame_ready && !valid)
      underrun_q <= 1'b1;
    else if (!enable_i)
      underrun_q <= 1'b0;
endmodule

// File: tb/tb_tone_sample_source.sv
// Randomised scoreboard bench for tone_sample_source.
// Reference samples come from plain integer waveform arithmetic.
module tb_tone_sample_source;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [23:0] tune_word;
  logic        tune_load;
  logic [1:0]  wave_sel;
  logic [2:0]  volume;
  logic [2:0]  fifo_level;
  logic        underrun;

  tone_sample_source_if bus ();

  tone_sample_source dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable),
    .tune_word_i (tune_word),
    .tune_load_i (tune_load),
    .wave_sel_i  (wave_sel),
    .volume_i    (volume),
    .frm         (bus),
    .fifo_level_o(fifo_level),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  int unsigned m_phase = 0;
  int unsigned m_tune  = 0;
  int          m_wave  = 0;
  int          m_vol   = 0;

  function automatic logic [31:0] model_frame(
    input int unsigned ph, input int w, input int v);
    int p;
    int s;
    logic [31:0] sv;
    p = int'((ph >> 8) & 32'hFFFF);
    case (w)
      0:       s = (p < 32768) ? 32767 : -32768;
      1:       s = p - 32768;
      2:       s = (p < 32768) ? (2 * p - 32768)
                               : (32767 - 2 * (p - 32768));
      default: s = 0;
    endcase
    s  = s >>> v;
    sv = s;
    return {sv[15:0], sv[15:0]};
  endfunction

  task automatic gen(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_frame(m_phase, m_wave, m_vol));
      m_phase = (m_phase + m_tune) & 32'h00FF_FFFF;
    end
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tune(input logic [23:0] t);
    tune_word = t;
    tune_load = 1'b1;
    tick();
    tune_load = 1'b0;
    m_tune = t;
  endtask

  // Scoreboard monitor: every accepted frame is checked in order.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.frame_valid === 1'b1 &&
        bus.frame_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_unexpected got %h want none",
                 bus.frame_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame", bus.frame_data, mon_exp);
      end
    end
  end

  task automatic fill_seg(input int w, input int v,
                          input logic [23:0] t,
                          input bit reload,
                          input logic [23:0] t2);
    enable   = 1'b0;
    wave_sel = 2'(w);
    volume   = 3'(v);
    m_wave   = w;
    m_vol    = v;
    set_tune(t);
    enable = 1'b1;
    gen(4);
    tick();
    check("lat_e1_valid", 32'(bus.frame_valid), 0);
    tick();
    check("lat_e2_valid", 32'(bus.frame_valid), 0);
    tick();
    check("lat_e3_valid", 32'(bus.frame_valid), 1);
    check("first_frame", bus.frame_data, exp_q[0]);
    repeat (9) tick();
    check("full_level", 32'(fifo_level), 4);
    check("full_head", bus.frame_data, exp_q[0]);
    if (reload) set_tune(t2);
    gen(2);
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("pulse_level", 32'(fifo_level), 3);
    tick();
    tick();
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
    check("pushpop_level", 32'(fifo_level), 3);
    repeat (8) tick();
    check("refill_level", 32'(fifo_level), 4);
    enable = 1'b0;
    repeat (30) begin
      bus.frame_ready = 1'($urandom);
      tick();
    end
    bus.frame_ready = 1'b1;
    repeat (6) tick();
    bus.frame_ready = 1'b0;
    tick();
    check("drain_level", 32'(fifo_level), 0);
    check("drain_valid", 32'(bus.frame_valid), 0);
    check("drain_underrun", 32'(underrun), 0);
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b0;
    tune_word       = '0;
    tune_load       = 1'b0;
    wave_sel        = '0;
    volume          = '0;
    bus.frame_ready = 1'b0;
    repeat (2) tick();
    check("rst_level", 32'(fifo_level), 0);
    check("rst_valid", 32'(bus.frame_valid), 0);
    check("rst_data", bus.frame_data, 0);
    check("rst_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    tick();

    fill_seg(0, 0, 24'h40_0000, 1'b0, 24'h0);
    fill_seg(1, 1, 24'h40_0000, 1'b0, 24'h0);
    fill_seg(2, 0, 24'h20_0000, 1'b0, 24'h0);
    for (int k = 0; k < 5; k++)
      fill_seg(int'($urandom_range(0, 3)),
               int'($urandom_range(0, 7)),
               24'($urandom), 1'($urandom),
               24'($urandom));

    wave_sel = 2'($urandom_range(0, 2));
    volume   = 3'($urandom_range(0, 7));
    m_wave   = int'(wave_sel);
    m_vol    = int'(volume);
    set_tune(24'($urandom));
    gen(40);
    enable          = 1'b1;
    bus.frame_ready = 1'b1;
    tick();
    check("underrun_set", 32'(underrun), 1);
    repeat (45) begin
      bus.frame_ready = 1'($urandom);
      tick();
    end
    check("underrun_sticky", 32'(underrun), 1);
    enable = 1'b0;
    tick();
    check("underrun_clear", 32'(underrun), 0);
    enable          = 1'b1;
    bus.frame_ready = 1'b0;
    repeat (7) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_level", 32'(fifo_level), 0);
    check("midrst_valid", 32'(bus.frame_valid), 0);
    check("midrst_data", bus.frame_data, 0);
    check("midrst_underrun", 32'(underrun), 0);
    exp_q.delete();
    m_phase = 0;
    m_tune  = 0;
    enable  = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    fill_seg(0, 2, 24'h40_0000, 1'b1, 24'h10_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
